snake_game_ctrl: RTL and testbench

Game-level sequencer for the snake datapath (`snake_body`, the FIFO-backed body tracker). It runs the start, run and game-over state machine, generates the periodic step strobe, and turns button pulses into a legal direction. On each score event it places a new prey from an LFSR and shortens the step period. It sits between the board's button/debounce logic and `snake_body`, and feeds head and prey coordinates to the VGA renderer.

---
 rtl/snake_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: start/run/over FSM, step strobe,
// direction filtering, score-driven speed-up and LFSR prey placement.
module snake_game_ctrl #(
  parameter int                         H_LOGIC_WIDTH = 5,
  parameter int                         V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX   = 5'd23,
  parameter int                         TICK_WIDTH    = 24,
  parameter logic [TICK_WIDTH-1:0]      TICK_INIT     = 24'd6_250_000,
  parameter logic [TICK_WIDTH-1:0]      TICK_STEP     = 24'd250_000,
  parameter logic [TICK_WIDTH-1:0]      TICK_MIN      = 24'd1_500_000,
  parameter int                         SCORE_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_start,
  input  logic                      btn_up,
  input  logic                      btn_down,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      snake_score,
  input  logic                      snake_lose,
  input  logic [H_LOGIC_WIDTH-1:0]  snake_headx,
  input  logic [V_LOGIC_WIDTH-1:0]  snake_heady,
  output logic                      snake_rst,
  output logic                      snake_enb,
  output logic                      snake_valid,
  output logic [1:0]                direction,
  output logic [H_LOGIC_WIDTH-1:0]  preyx,
  output logic [V_LOGIC_WIDTH-1:0]  preyy,
  output logic                      prey_vld,
  output logic [SCORE_WIDTH-1:0]    score_cnt,
  output logic [1:0]                game_state
);

  typedef enum logic [1:0] {IDLE = 2'b00, INIT = 2'b01, RUN = 2'b10, OVER = 2'b11} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;
  localparam logic [H_LOGIC_WIDTH-1:0] PREY_X0 = H_LOGIC_WIDTH'(24);
  localparam logic [V_LOGIC_WIDTH-1:0] PREY_Y0 = V_LOGIC_WIDTH'(11);
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  state_t                   state;
  logic [1:0]               init_cnt;
  logic [1:0]               pending;
  logic [TICK_WIDTH-1:0]    period;
  logic [TICK_WIDTH-1:0]    tick_cnt;
  logic [9:0]               lfsr;
  logic                     searching;
  logic                     press;
  logic [1:0]               press_dir;
  logic                     tick;
  logic                     start_game;
  logic                     period_floor;
  logic [H_LOGIC_WIDTH-1:0] raw_x;
  logic [V_LOGIC_WIDTH-1:0] raw_y;
  logic [H_LOGIC_WIDTH-1:0] cand_x;
  logic [V_LOGIC_WIDTH-1:0] cand_y;

  always_comb begin
    press     = 1'b1;
    press_dir = DIR_UP;
    if (btn_up)         press_dir = DIR_UP;
    else if (btn_down)  press_dir = DIR_DOWN;
    else if (btn_left)  press_dir = DIR_LEFT;
    else if (btn_right) press_dir = DIR_RIGHT;
    else                press = 1'b0;
  end

  // Candidates outside the playfield fold back by one board size.
  assign raw_x  = lfsr[H_LOGIC_WIDTH-1:0];
  assign raw_y  = lfsr[H_LOGIC_WIDTH +: V_LOGIC_WIDTH];
  assign cand_x = ({1'b0, raw_x} > {1'b0, H_LOGIC_MAX}) ?
                  raw_x - (H_LOGIC_MAX + H_LOGIC_WIDTH'(1)) : raw_x;
  assign cand_y = ({1'b0, raw_y} > {1'b0, V_LOGIC_MAX}) ?
                  raw_y - (V_LOGIC_MAX + V_LOGIC_WIDTH'(1)) : raw_y;

  // ">=" lets a shortened period wrap a counter that is already past it.
  assign tick         = (state == RUN) && (tick_cnt >= period - TICK_WIDTH'(1));
  assign start_game   = btn_start && ((state == IDLE) || (state == OVER));
  assign period_floor = ({1'b0, period} < ({1'b0, TICK_STEP} + {1'b0, TICK_MIN}));
  assign snake_rst    = rst | ((state == INIT) && (init_cnt == 2'd0));
  assign game_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      init_cnt    <= 2'd0;
      pending     <= DIR_RIGHT;
      direction   <= DIR_RIGHT;
      period      <= TICK_INIT;
      tick_cnt    <= '0;
      lfsr        <= LFSR_SEED;
      searching   <= 1'b0;
      snake_enb   <= 1'b0;
      snake_valid <= 1'b0;
      preyx       <= PREY_X0;
      preyy       <= PREY_Y0;
      prey_vld    <= 1'b1;
      score_cnt   <= '0;
    end else begin
      lfsr        <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      snake_valid <= 1'b0;

      if (press && (press_dir != ~direction)) pending <= press_dir;

      if (searching && ((cand_x != snake_headx) || (cand_y != snake_heady))) begin
        preyx     <= cand_x;
        preyy     <= cand_y;
        prey_vld  <= 1'b1;
        searching <= 1'b0;
      end

      case (state)
        INIT: begin
          if (init_cnt == 2'd3) begin
            state     <= RUN;
            snake_enb <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 2'd1;
          end
        end
        RUN: begin
          if (snake_lose) begin
            state     <= OVER;
            snake_enb <= 1'b0;
          end else if (tick) begin
            snake_valid <= 1'b1;
            tick_cnt    <= '0;
            direction   <= pending;
          end else begin
            tick_cnt <= tick_cnt + TICK_WIDTH'(1);
          end
          if (snake_score) begin
            if (score_cnt != '1) score_cnt <= score_cnt + SCORE_WIDTH'(1);
            period    <= period_floor ? TICK_MIN : period - TICK_STEP;
            prey_vld  <= 1'b0;
            searching <= 1'b1;
          end
        end
        default: ;
      endcase

      if (start_game) begin
        state     <= INIT;
        init_cnt  <= 2'd0;
        period    <= TICK_INIT;
        tick_cnt  <= '0;
        direction <= DIR_RIGHT;
        pending   <= DIR_RIGHT;
        score_cnt <= '0;
        preyx     <= PREY_X0;
        preyy     <= PREY_Y0;
        prey_vld  <= 1'b1;
        searching <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed game scenarios plus random play, all
// compared cycle by cycle against an integer-level model of the game rules.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       snake_score = 1'b0, snake_lose = 1'b0;
  logic [4:0] snake_headx = '0, snake_heady = '0;
  logic       snake_rst, snake_enb, snake_valid, prey_vld;
  logic [1:0] direction, game_state;
  logic [4:0] preyx, preyy;
  logic [7:0] score_cnt;

  snake_game_ctrl #(
    .TICK_INIT(24'd8), .TICK_STEP(24'd2), .TICK_MIN(24'd4)
  ) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .snake_score(snake_score), .snake_lose(snake_lose),
    .snake_headx(snake_headx), .snake_heady(snake_heady),
    .snake_rst(snake_rst), .snake_enb(snake_enb), .snake_valid(snake_valid),
    .direction(direction), .preyx(preyx), .preyy(preyy), .prey_vld(prey_vld),
    .score_cnt(score_cnt), .game_state(game_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 init, 2 run, 3 over.
  int m_state, m_init, m_period, m_cnt, m_dir, m_pend, m_score;
  int m_px, m_py, m_pvld, m_search, m_lfsr, m_valid, m_enb;

  function automatic int lfsr_next(input int l);
    return ((l << 1) & 'h3FF) | (((l >> 9) ^ (l >> 6)) & 1);
  endfunction

  task automatic cand(input int l, output int x, output int y);
    x = l % 32;
    y = l / 32;
    if (y > 23) y -= 24;
  endtask

  task automatic model_reset();
    m_state = 0; m_init = 0; m_period = 8; m_cnt = 0; m_dir = 1; m_pend = 1;
    m_score = 0; m_px = 24; m_py = 11; m_pvld = 1; m_search = 0;
    m_lfsr = 'h2A5; m_valid = 0; m_enb = 0;
  endtask

  task automatic model_step();
    int st0, pend0, cx, cy, code;
    bit do_tick;
    if (rst) begin
      model_reset();
      return;
    end
    st0     = m_state;
    pend0   = m_pend;
    do_tick = (m_state == 2) && !snake_lose && (m_cnt >= m_period - 1);
    cand(m_lfsr, cx, cy);
    m_lfsr  = lfsr_next(m_lfsr);
    m_valid = 0;
    code = -1;
    if (btn_up) code = 0;
    else if (btn_down) code = 3;
    else if (btn_left) code = 2;
    else if (btn_right) code = 1;
    if (code >= 0 && code != 3 - m_dir) m_pend = code;
    if (m_search && !(cx == snake_headx && cy == snake_heady)) begin
      m_px = cx; m_py = cy; m_pvld = 1; m_search = 0;
    end
    if (st0 == 1) begin
      if (m_init == 3) begin m_state = 2; m_enb = 1; end
      else m_init++;
    end else if (st0 == 2) begin
      if (snake_lose) begin m_state = 3; m_enb = 0; end
      else if (do_tick) begin m_valid = 1; m_cnt = 0; m_dir = pend0; end
      else m_cnt++;
      if (snake_score) begin
        if (m_score < 255) m_score++;
        m_period = (m_period - 2 < 4) ? 4 : m_period - 2;
        m_pvld = 0; m_search = 1;
      end
    end
    if (btn_start && (st0 == 0 || st0 == 3)) begin
      m_state = 1; m_init = 0; m_period = 8; m_cnt = 0; m_dir = 1; m_pend = 1;
      m_score = 0; m_px = 24; m_py = 11; m_pvld = 1; m_search = 0;
    end
  endtask

  task automatic compare_all();
    check("snake_rst", snake_rst, (rst || (m_state == 1 && m_init == 0)) ? 1 : 0);
    check("snake_enb", snake_enb, m_enb);
    check("snake_valid", snake_valid, m_valid);
    check("direction", direction, m_dir);
    check("preyx", preyx, m_px);
    check("preyy", preyy, m_py);
    check("prey_vld", prey_vld, m_pvld);
    check("score_cnt", score_cnt, m_score);
    check("game_state", game_state, m_state);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1 model_step();
    @(negedge clk);
    compare_all();
    btn_start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    snake_score = 0; snake_lose = 0;
  endtask

  task automatic wait_tick(input string tag, output int k);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!snake_valid && k < 30);
    if (!snake_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_prey(input string tag);
    int k = 0;
    while (!prey_vld && k < 40) begin cycle(); k++; end
    check({tag, "_prey_settled"}, prey_vld, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, game_state, 0);
    check({tag, "_snake_rst"}, snake_rst, 1);
    check({tag, "_enb"}, snake_enb, 0);
    check({tag, "_valid"}, snake_valid, 0);
    check({tag, "_dir"}, direction, 1);
    check({tag, "_preyx"}, preyx, 24);
    check({tag, "_preyy"}, preyy, 11);
    check({tag, "_prey_vld"}, prey_vld, 1);
    check({tag, "_score"}, score_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hx, hy;
    model_reset();
    rst = 1;
    repeat (2) cycle();
    check_reset_values("reset");
    rst = 0;
    cycle();

    // Start sequence and tick spacing.
    btn_start = 1;
    cycle();
    check("init_first_snake_rst", snake_rst, 1);
    check("init_state", game_state, 1);
    cycle();
    check("init_second_snake_rst", snake_rst, 0);
    repeat (2) cycle();
    check("init_last_state", game_state, 1);
    cycle();
    check("run_entry_state", game_state, 2);
    wait_tick("first_tick", k);
    check("first_tick_delay", k, 8);
    wait_tick("second_tick", k);
    check("tick_period", k, 8);
    check("start_direction", direction, 1);

    // Reversal is ignored; last legal press wins at the tick.
    btn_left = 1;
    cycle();
    btn_up = 1;
    cycle();
    btn_down = 1;
    cycle();
    check("dir_before_tick", direction, 1);
    wait_tick("rev_tick", k);
    check("dir_after_tick", direction, 3);
    btn_up = 1;
    cycle();
    wait_tick("rev_tick2", k);
    check("dir_reverse_ignored", direction, 3);

    // Speed-up to the floor.
    snake_headx = 0; snake_heady = 0;
    repeat (3) begin
      snake_score = 1;
      cycle();
      repeat (9) cycle();
    end
    check("score_three", score_cnt, 3);
    wait_tick("floor_tick_a", k);
    wait_tick("floor_tick_b", k);
    check("period_floor", k, 4);

    // Prey respawn with the first candidate sitting on the head.
    wait_prey("respawn_pre");
    cand(lfsr_next(m_lfsr), hx, hy);
    snake_headx = hx[4:0]; snake_heady = hy[4:0];
    snake_score = 1;
    cycle();
    check("respawn_vld_low1", prey_vld, 0);
    cycle();
    check("respawn_vld_low2", prey_vld, 0);
    wait_prey("respawn");
    check("respawn_not_head", (preyx == snake_headx && preyy == snake_heady) ? 1 : 0, 0);
    check("respawn_y_range", (preyy <= 23) ? 1 : 0, 1);

    // Lose in the tick cycle.
    k = 0;
    while (!(m_state == 2 && m_cnt == m_period - 1) && k < 20) begin cycle(); k++; end
    check("lose_align", (m_state == 2 && m_cnt == m_period - 1) ? 1 : 0, 1);
    snake_lose = 1;
    cycle();
    check("lose_state", game_state, 3);
    check("lose_no_valid", snake_valid, 0);
    check("lose_enb", snake_enb, 0);
    repeat (3) cycle();
    check("over_score_hold", score_cnt, 4);
    btn_start = 1;
    cycle();
    check("restart_state", game_state, 1);
    check("restart_score", score_cnt, 0);
    check("restart_preyx", preyx, 24);
    check("restart_preyy", preyy, 11);

    // Random play.
    for (int i = 0; i < 600; i++) begin
      snake_headx = 5'($urandom_range(0, 31));
      snake_heady = 5'($urandom_range(0, 23));
      if (m_state == 0 || m_state == 3) btn_start = ($urandom_range(0, 7) == 0);
      else btn_start = ($urandom_range(0, 31) == 0);
      btn_up    = ($urandom_range(0, 9) == 0);
      btn_down  = ($urandom_range(0, 9) == 0);
      btn_left  = ($urandom_range(0, 9) == 0);
      btn_right = ($urandom_range(0, 9) == 0);
      if (m_state == 2) begin
        snake_lose  = ($urandom_range(0, 59) == 0);
        snake_score = ($urandom_range(0, 14) == 0);
      end
      cycle();
    end

    // Reset while a prey search is in progress.
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    btn_start = 1;
    cycle();
    repeat (5) cycle();
    cand(lfsr_next(m_lfsr), hx, hy);
    snake_headx = hx[4:0]; snake_heady = hy[4:0];
    snake_score = 1;
    cycle();
    check("search_active", prey_vld, 0);
    rst = 1;
    cycle();
    check_reset_values("midrun_reset");
    rst = 0;
    cycle();
    check("post_reset_state", game_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
